// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver. It deserializes LSB-first codewords, corrects single-bit
// errors, and holds each nibble in a valid/ready output register next to the link-health counters.
module hamming_serial_rx #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    input  logic             sof_i,
    output logic [3:0]       data_o,
    output logic [2:0]       syn_o,
    output logic             err_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             abort_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [CNT_W-1:0] corr_cnt_o,
    input  logic             clr_cnt_i
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [5:0] sreg;

    logic [6:0] cw;
    logic [6:0] cw_fix;
    logic [2:0] syn;
    logic [3:0] data_fix;
    logic       complete;
    logic       load;
    logic       drop;

    assign busy_o   = (state == ST_SHIFT);
    assign complete = (state == ST_SHIFT) && bit_valid_i && !sof_i && (bit_cnt == 3'd6);
    assign load     = complete && (!out_valid_o || out_ready_i);
    assign drop     = complete && !load;

    // The 7th bit is still on bit_i here, so the decode sees the full word on the completing edge.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        cw     = {bit_i, sreg};
        syn    = {^(cw & 7'b1111000), ^(cw & 7'b1100110), ^(cw & 7'b1010101)};
        cw_fix = cw;
        if (syn != 3'd0)
            cw_fix[syn - 3'd1] = ~cw[syn - 3'd1];
        data_fix = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state updates use non-blocking assignments only.
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            sreg    <= 6'd0;
            abort_o <= 1'b0;
        end else begin
            abort_o <= 1'b0;
            if (bit_valid_i) begin
                if (sof_i) begin
                    // A new sof restarts framing. Any partial word in progress is discarded.
                    abort_o <= (state == ST_SHIFT);
                    sreg    <= {5'd0, bit_i};
                    bit_cnt <= 3'd1;
                    state   <= ST_SHIFT;
                end else if (state == ST_SHIFT) begin
                    if (bit_cnt == 3'd6) begin
                        state   <= ST_IDLE;
                        bit_cnt <= 3'd0;
                    end else begin
                        sreg[bit_cnt] <= bit_i;
                        bit_cnt       <= bit_cnt + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o      <= 4'd0;
            syn_o       <= 3'd0;
            err_o       <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (load) begin
            data_o      <= data_fix;
            syn_o       <= syn;
            err_o       <= (syn != 3'd0);
            out_valid_o <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // A clear takes priority over a coincident increment or overflow event.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt_i) begin
            word_cnt_o <= '0;
            corr_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (load && !(&word_cnt_o))
                word_cnt_o <= word_cnt_o + 1'b1;
            if (load && (syn != 3'd0) && !(&corr_cnt_o))
                corr_cnt_o <= corr_cnt_o + 1'b1;
            if (drop)
                overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Randomized self-checking bench for hamming_serial_rx. A second instance with CNT_W=2
// receives the same stimulus, so counter saturation is checked alongside the 16-bit instance.
module tb_hamming_serial_rx;

    logic clk = 1'b0;
    logic rst, bit_i, bit_valid_i, sof_i, out_ready_i, clr_cnt_i;

    logic [3:0]  data_o;
    logic [2:0]  syn_o;
    logic        err_o, out_valid_o, busy_o, abort_o, overflow_o;
    logic [15:0] word_cnt_o, corr_cnt_o;

    logic [3:0]  s_data;
    logic [2:0]  s_syn;
    logic        s_err, s_valid, s_busy, s_abort, s_ovf;
    logic [1:0]  s_word_cnt, s_corr_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    hamming_serial_rx #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i), .sof_i(sof_i),
        .data_o(data_o), .syn_o(syn_o), .err_o(err_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o), .abort_o(abort_o),
        .overflow_o(overflow_o), .word_cnt_o(word_cnt_o), .corr_cnt_o(corr_cnt_o),
        .clr_cnt_i(clr_cnt_i)
    );

    hamming_serial_rx #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i), .sof_i(sof_i),
        .data_o(s_data), .syn_o(s_syn), .err_o(s_err), .out_valid_o(s_valid),
        .out_ready_i(out_ready_i), .busy_o(s_busy), .abort_o(s_abort),
        .overflow_o(s_ovf), .word_cnt_o(s_word_cnt), .corr_cnt_o(s_corr_cnt),
        .clr_cnt_i(clr_cnt_i)
    );

    // Reference model state. The counters are kept unbounded and clamped only when compared.
    bit       m_in_frame;
    int       m_nbits;
    bit [6:0] m_word;
    bit       m_valid, m_err, m_abort, m_ovf;
    bit [3:0] m_data;
    bit [2:0] m_syn;
    int       m_words, m_corrs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The syndrome is the XOR of the 1-based positions of all set bits.
    function automatic bit [2:0] syndrome(input bit [6:0] cw);
        bit [2:0] s = 3'd0;
        for (int i = 0; i < 7; i++)
            if (cw[i]) s = s ^ 3'(i + 1);
        return s;
    endfunction

    function automatic bit [6:0] encode(input bit [3:0] d);
        bit [6:0] cw = 7'd0;
        bit [2:0] s;
        cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
        s = syndrome(cw);
        cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
        return cw;
    endfunction

    function automatic int clamp(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step();
        bit complete = 1'b0;
        bit old_valid = m_valid;
        bit [6:0] fix;
        m_abort = 1'b0;
        if (rst) begin
            m_in_frame = 0; m_nbits = 0; m_word = 0; m_valid = 0; m_err = 0;
            m_data = 0; m_syn = 0; m_ovf = 0; m_words = 0; m_corrs = 0;
            return;
        end
        if (bit_valid_i) begin
            if (sof_i) begin
                m_abort = m_in_frame;
                m_in_frame = 1; m_nbits = 1; m_word = {6'd0, bit_i};
            end else if (m_in_frame) begin
                m_word[m_nbits] = bit_i;
                m_nbits++;
                if (m_nbits == 7) begin
                    complete = 1'b1; m_in_frame = 0; m_nbits = 0;
                end
            end
        end
        if (complete && (!old_valid || out_ready_i)) begin
            m_syn = syndrome(m_word);
            fix = m_word;
            if (m_syn != 0) fix[m_syn - 1] = ~fix[m_syn - 1];
            m_data = {fix[6], fix[5], fix[4], fix[2]};
            m_err = (m_syn != 0);
            m_valid = 1; m_words++;
            if (m_err) m_corrs++;
        end else begin
            if (complete) m_ovf = 1;
            if (old_valid && out_ready_i) m_valid = 0;
        end
        if (clr_cnt_i) begin
            m_words = 0; m_corrs = 0; m_ovf = 0;
        end
    endtask

    // Apply the currently driven inputs for one edge, then compare both DUTs with the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("out_valid", out_valid_o, m_valid);
        if (m_valid) begin
            check("data", data_o, m_data);
            check("syn", syn_o, m_syn);
            check("err", err_o, m_err);
        end
        check("busy", busy_o, m_in_frame);
        check("abort", abort_o, m_abort);
        check("overflow", overflow_o, m_ovf);
        check("word_cnt", word_cnt_o, clamp(m_words, 65535));
        check("corr_cnt", corr_cnt_o, clamp(m_corrs, 65535));
        check("sat_word_cnt", s_word_cnt, clamp(m_words, 3));
        check("sat_corr_cnt", s_corr_cnt, clamp(m_corrs, 3));
    endtask

    task automatic idle(input int n);
        bit_valid_i = 0; sof_i = 0; bit_i = 0; clr_cnt_i = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Send bits first..last of cw, LSB first. A stall is inserted with probability gap_pct.
    task automatic send_bits(input bit [6:0] cw, input int first, input int last,
                             input bit with_sof, input int gap_pct, input bit clr_last);
        for (int i = first; i <= last; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bit_valid_i = 0; sof_i = 0; bit_i = $urandom; clr_cnt_i = 0;
                tick();
            end
            bit_valid_i = 1; bit_i = cw[i];
            sof_i = with_sof && (i == first);
            clr_cnt_i = clr_last && (i == last);
            tick();
        end
        bit_valid_i = 0; sof_i = 0; clr_cnt_i = 0;
    endtask

    task automatic send_frame(input bit [6:0] cw, input int gap_pct);
        send_bits(cw, 0, 6, 1'b1, gap_pct, 1'b0);
    endtask

    initial begin
        rst = 1; bit_i = 0; bit_valid_i = 0; sof_i = 0; out_ready_i = 1; clr_cnt_i = 0;
        tick(); tick();
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_data", data_o, 4'd0);
        check("rst_wcnt", word_cnt_o, 16'd0);
        rst = 0;
        idle(2);

        // Clean word and single-bit errors at cw[5] and cw[0].
        send_frame(7'b1010101, 0);
        check("tp1_data", data_o, 4'b1011);
        check("tp1_syn", syn_o, 3'd0);
        check("tp1_wcnt", word_cnt_o, 16'd1);
        send_frame(7'b1110101, 0);
        check("tp2a_syn", syn_o, 3'b110);
        check("tp2a_data", data_o, 4'b1011);
        check("tp2a_ccnt", corr_cnt_o, 16'd1);
        send_frame(7'b1010100, 0);
        check("tp2b_syn", syn_o, 3'b001);
        check("tp2b_data", data_o, 4'b1011);

        // Three bits with stalls, then a new sof aborts the partial frame.
        send_bits(7'b0110011, 0, 2, 1'b1, 40, 1'b0);
        send_frame(encode(4'b0110), 30);
        check("tp3_data", data_o, 4'b0110);
        check("tp3_wcnt", word_cnt_o, 16'd4);

        // Backpressure: the first word is held and the second is dropped.
        idle(2);
        out_ready_i = 0;
        send_frame(encode(4'b1001), 0);
        send_frame(encode(4'b0011), 0);
        check("tp4_held", data_o, 4'b1001);
        check("tp4_ovf", overflow_o, 1'b1);
        out_ready_i = 1;
        send_bits(encode(4'b1111), 0, 6, 1'b1, 0, 1'b1);
        check("tp4_clr_wcnt", word_cnt_o, 16'd0);
        check("tp4_clr_ovf", overflow_o, 1'b0);
        check("tp4_clr_data", data_o, 4'b1111);

        // Reset after four bits. The remaining bits arrive without sof and must be ignored.
        send_bits(encode(4'b0101), 0, 3, 1'b1, 0, 1'b0);
        rst = 1; tick(); rst = 0;
        send_bits(encode(4'b0101), 4, 6, 1'b0, 0, 1'b0);
        check("tp5_valid", out_valid_o, 1'b0);
        check("tp5_busy", busy_o, 1'b0);
        send_frame(encode(4'b1100), 0);
        check("tp5_data", data_o, 4'b1100);

        // Five corrected words saturate the 2-bit counters.
        for (int i = 0; i < 5; i++) send_frame(encode(4'(i)) ^ 7'b0001000, 0);
        check("tp6_sat_w", s_word_cnt, 2'd3);
        check("tp6_sat_c", s_corr_cnt, 2'd3);

        // Random traffic: random data, 0/1/2-bit errors, stalls, ready, aborts and clears.
        for (int n = 0; n < 300; n++) begin
            bit [6:0] cw = encode(4'($urandom));
            int e = $urandom_range(2);
            for (int k = 0; k < e; k++) cw[$urandom_range(6)] ^= 1'b1;
            out_ready_i = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0)
                send_bits(cw, 0, $urandom_range(5), 1'b1, 20, 1'b0);
            send_bits(cw, 0, 6, 1'b1, 25, ($urandom_range(19) == 0));
            if ($urandom_range(3) == 0) idle($urandom_range(3));
        end
        out_ready_i = 1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
